uart_rx_fifo: RTL and testbench

- Parametrised successor to the team's fixed 8N1 UART receiver.
- Adds configurable data width, parity and stop bits, an input synchroniser, 3-sample majority voting, error reporting and a first-word-fall-through receive FIFO.
- Sits between the external RX pin and the CPU's memory-mapped UART register interface.
- The CPU pops bytes at its leisure instead of catching a one-cycle strobe.

---
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, 3-sample majority voting,
// one-cycle error pulses and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 120,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        I_clk,
    input  logic                        I_reset,
    input  logic                        I_data_bit,
    input  logic                        I_read,
    output logic                        O_ready,
    output logic                        O_data_ready,
    output logic [DATA_BITS-1:0]        O_data,
    output logic [$clog2(FIFO_DEPTH):0] O_count,
    output logic                        O_frame_error,
    output logic                        O_parity_error,
    output logic                        O_overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int M  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0    = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(M);
    localparam logic [CW-1:0] CNT_DEC   = CW'(M + 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARBIT, STOP} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic                 samp0_q, samp0_d, samp1_q, samp1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parBit_q, parBit_d;
    logic                 stopErr_q, stopErr_d;
    logic                 frameErr_q, frameErr_d;
    logic                 parityErr_q, parityErr_d;
    logic                 overrun_q, overrun_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wrPtr_q, rdPtr_q;

    logic rxS, vote, decide, wrapCnt, parityBad, frameEnd, frameGood;
    logic fifoFull, fifoEmpty, doRead, doWrite;

    assign rxS     = sync2_q;
    assign vote    = (samp0_q & samp1_q) | (samp0_q & rxS) | (samp1_q & rxS);
    assign decide  = (cnt_q == CNT_DEC);
    assign wrapCnt = (cnt_q == CNT_LAST);

    always_comb begin
        parityBad = 1'b0;
        if (PARITY == 1) parityBad = ~(^{shift_q, parBit_q});
        else if (PARITY == 2) parityBad = ^{shift_q, parBit_q};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitIdx_d    = bitIdx_q;
        samp0_d     = samp0_q;
        samp1_d     = samp1_q;
        shift_d     = shift_q;
        parBit_d    = parBit_q;
        stopErr_d   = stopErr_q;
        frameEnd    = 1'b0;
        frameErr_d  = 1'b0;
        parityErr_d = 1'b0;
        if (state_q != IDLE) begin
            cnt_d = wrapCnt ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) samp0_d = rxS;
            if (cnt_q == CNT_S1) samp1_d = rxS;
        end
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bitIdx_d  = '0;
                stopErr_d = 1'b0;
                if (!rxS) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                if (decide && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (wrapCnt) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (wrapCnt) begin
                    if (bitIdx_q == LAST_DATA) begin
                        bitIdx_d = '0;
                        state_d  = (PARITY != 0) ? PARBIT : STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end
            end
            PARBIT: begin
                if (decide) parBit_d = vote;
                if (wrapCnt) state_d = STOP;
            end
            STOP: begin
                // The last stop bit ends the frame at its midpoint so the next start edge is never missed.
                if (decide && bitIdx_q == LAST_STOP) begin
                    frameEnd    = 1'b1;
                    frameErr_d  = stopErr_q | ~vote;
                    parityErr_d = parityBad;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end else begin
                    if (decide) stopErr_d = stopErr_q | ~vote;
                    if (wrapCnt) bitIdx_d = bitIdx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = ((wrPtr_q ^ rdPtr_q) == {1'b1, {AW{1'b0}}});
    assign doRead    = I_read & ~fifoEmpty;
    assign frameGood = frameEnd & ~frameErr_d & ~parityErr_d;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the frame.
    assign doWrite   = frameGood & (~fifoFull | doRead);
    assign overrun_d = frameGood & fifoFull & ~doRead;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            samp0_q     <= 1'b1;
            samp1_q     <= 1'b1;
            shift_q     <= '0;
            parBit_q    <= 1'b0;
            stopErr_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            parityErr_q <= 1'b0;
            overrun_q   <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            sync1_q     <= I_data_bit;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            samp0_q     <= samp0_d;
            samp1_q     <= samp1_d;
            shift_q     <= shift_d;
            parBit_q    <= parBit_d;
            stopErr_q   <= stopErr_d;
            frameErr_q  <= frameErr_d;
            parityErr_q <= parityErr_d;
            overrun_q   <= overrun_d;
            if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
            if (doRead) rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset && doWrite) mem_q[wrPtr_q[AW-1:0]] <= shift_q;
    end

    assign O_ready        = (state_q == IDLE);
    assign O_data_ready   = ~fifoEmpty;
    assign O_data         = mem_q[rdPtr_q[AW-1:0]];
    assign O_count        = wrPtr_q - rdPtr_q;
    assign O_frame_error  = frameErr_q;
    assign O_parity_error = parityErr_q;
    assign O_overrun      = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances (8N1, 8E1, 7N2) share one
// serial driver that is routed to the instance under test.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       txLine   = 1'b1;
    logic       readLine = 1'b0;
    logic [1:0] route    = 2'd0;
    logic       resetA = 1'b1, resetB = 1'b1, resetC = 1'b1;
    logic       rxA, rxB, rxC, readA, readB, readC;

    assign rxA   = (route == 2'd0) ? txLine : 1'b1;
    assign rxB   = (route == 2'd1) ? txLine : 1'b1;
    assign rxC   = (route == 2'd2) ? txLine : 1'b1;
    assign readA = (route == 2'd0) ? readLine : 1'b0;
    assign readB = (route == 2'd1) ? readLine : 1'b0;
    assign readC = (route == 2'd2) ? readLine : 1'b0;

    logic       readyA, dataReadyA, feA, peA, ovA;
    logic [7:0] dataA;
    logic [2:0] countA;
    logic       readyB, dataReadyB, feB, peB, ovB;
    logic [7:0] dataB;
    logic [2:0] countB;
    logic       readyC, dataReadyC, feC, peC, ovC;
    logic [6:0] dataC;
    logic [2:0] countC;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
        .I_clk(clk), .I_reset(resetA), .I_data_bit(rxA), .I_read(readA),
        .O_ready(readyA), .O_data_ready(dataReadyA), .O_data(dataA), .O_count(countA),
        .O_frame_error(feA), .O_parity_error(peA), .O_overrun(ovA));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dutB (
        .I_clk(clk), .I_reset(resetB), .I_data_bit(rxB), .I_read(readB),
        .O_ready(readyB), .O_data_ready(dataReadyB), .O_data(dataB), .O_count(countB),
        .O_frame_error(feB), .O_parity_error(peB), .O_overrun(ovB));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dutC (
        .I_clk(clk), .I_reset(resetC), .I_data_bit(rxC), .I_read(readC),
        .O_ready(readyC), .O_data_ready(dataReadyC), .O_data(dataC), .O_count(countC),
        .O_frame_error(feC), .O_parity_error(peC), .O_overrun(ovC));

    int vectors = 0;
    int miscompares = 0;
    int feCnt [3] = '{0, 0, 0};
    int peCnt [3] = '{0, 0, 0};
    int ovCnt [3] = '{0, 0, 0};

    // Pulses are one full cycle wide, so each is seen by exactly one falling edge.
    always @(negedge clk) begin
        if (feA) feCnt[0]++;
        if (peA) peCnt[0]++;
        if (ovA) ovCnt[0]++;
        if (feB) feCnt[1]++;
        if (peB) peCnt[1]++;
        if (ovB) ovCnt[1]++;
        if (feC) feCnt[2]++;
        if (peC) peCnt[2]++;
        if (ovC) ovCnt[2]++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; optionally spikes one data bit at its midpoint or pulses
    // I_read on the cycle the frame is written.
    task automatic applyStimulus(input logic [7:0] data, input int nData, input int hasPar,
                                 input logic parBit, input int nStop, input logic [1:0] stopVals,
                                 input int spikeIdx, input int readAtWrite);
        txLine = 1'b0;
        tick(CPB);
        for (int i = 0; i < nData; i++) begin
            txLine = data[i];
            if (i == spikeIdx) begin
                tick(CPB / 2);
                txLine = ~data[i];
                tick(1);
                txLine = data[i];
                tick(CPB / 2 - 1);
            end else begin
                tick(CPB);
            end
        end
        if (hasPar != 0) begin
            txLine = parBit;
            tick(CPB);
        end
        for (int s = 0; s < nStop; s++) begin
            txLine = stopVals[s];
            if (readAtWrite != 0 && s == nStop - 1) begin
                tick(11);
                readLine = 1'b1;
                tick(1);
                readLine = 1'b0;
                tick(4);
            end else begin
                tick(CPB);
            end
        end
        txLine = 1'b1;
        tick(20);
    endtask

    task automatic popRead();
        readLine = 1'b1;
        tick(1);
        readLine = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        tick(3);
        checkOutput("rst_readyA", 32'(readyA), 32'd1);
        checkOutput("rst_dreadyA", 32'(dataReadyA), 32'd0);
        checkOutput("rst_countA", 32'(countA), 32'd0);
        checkOutput("rst_pulsesA", 32'({feA, peA, ovA}), 32'd0);
        checkOutput("rst_countC", 32'(countC), 32'd0);
        resetA = 1'b0;
        resetB = 1'b0;
        resetC = 1'b0;
        tick(2);

        route = 2'd0;
        applyStimulus(8'hA5, 8, 0, 1'b0, 1, 2'b11, -1, 0);
        applyStimulus(8'h3C, 8, 0, 1'b0, 1, 2'b11, -1, 0);
        checkOutput("two_count", 32'(countA), 32'd2);
        checkOutput("two_dready", 32'(dataReadyA), 32'd1);
        checkOutput("two_head", 32'(dataA), 32'hA5);
        popRead();
        checkOutput("two_second", 32'(dataA), 32'h3C);
        popRead();
        checkOutput("two_empty", 32'(dataReadyA), 32'd0);
        checkOutput("two_noerr", 32'(feCnt[0] + peCnt[0] + ovCnt[0]), 32'd0);

        applyStimulus(8'h55, 8, 0, 1'b0, 1, 2'b00, -1, 0);
        checkOutput("ferr_pulse", 32'(feCnt[0]), 32'd1);
        checkOutput("ferr_count", 32'(countA), 32'd0);
        applyStimulus(8'hFF, 8, 0, 1'b0, 1, 2'b11, -1, 0);
        checkOutput("after_ferr_count", 32'(countA), 32'd1);
        checkOutput("after_ferr_data", 32'(dataA), 32'hFF);
        popRead();

        txLine = 1'b0;
        tick(3);
        txLine = 1'b1;
        tick(2);
        checkOutput("glitch_start", 32'(readyA), 32'd0);
        tick(20);
        checkOutput("glitch_idle", 32'(readyA), 32'd1);
        checkOutput("glitch_count", 32'(countA), 32'd0);
        checkOutput("glitch_pulses", 32'(feCnt[0] + peCnt[0] + ovCnt[0]), 32'd1);

        applyStimulus(8'h96, 8, 0, 1'b0, 1, 2'b11, 2, 0);
        checkOutput("spike_count", 32'(countA), 32'd1);
        checkOutput("spike_data", 32'(dataA), 32'h96);
        popRead();

        for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 8, 0, 1'b0, 1, 2'b11, -1, 0);
        checkOutput("ovr_count", 32'(countA), 32'd4);
        checkOutput("ovr_pulse", 32'(ovCnt[0]), 32'd1);
        for (int b = 1; b <= 4; b++) begin
            checkOutput("ovr_readout", 32'(dataA), 32'(b));
            popRead();
        end
        checkOutput("ovr_drained", 32'(dataReadyA), 32'd0);

        for (int b = 1; b <= 4; b++) applyStimulus(8'(b), 8, 0, 1'b0, 1, 2'b11, -1, 0);
        applyStimulus(8'h05, 8, 0, 1'b0, 1, 2'b11, -1, 1);
        checkOutput("rdwr_count", 32'(countA), 32'd4);
        checkOutput("rdwr_noovr", 32'(ovCnt[0]), 32'd1);
        for (int b = 2; b <= 5; b++) begin
            checkOutput("rdwr_readout", 32'(dataA), 32'(b));
            popRead();
        end

        route = 2'd1;
        applyStimulus(8'h07, 8, 1, 1'b0, 1, 2'b11, -1, 0);
        checkOutput("par_bad_pulse", 32'(peCnt[1]), 32'd1);
        checkOutput("par_bad_count", 32'(countB), 32'd0);
        applyStimulus(8'h07, 8, 1, 1'b1, 1, 2'b11, -1, 0);
        checkOutput("par_ok_count", 32'(countB), 32'd1);
        checkOutput("par_ok_data", 32'(dataB), 32'h07);
        checkOutput("par_ok_pulses", 32'(peCnt[1] + feCnt[1]), 32'd1);

        route = 2'd2;
        applyStimulus(8'h5A, 7, 0, 1'b0, 2, 2'b01, -1, 0);
        checkOutput("stop2_ferr", 32'(feCnt[2]), 32'd1);
        checkOutput("stop2_count", 32'(countC), 32'd0);
        applyStimulus(8'h2B, 7, 0, 1'b0, 2, 2'b11, -1, 0);
        checkOutput("c_good_count", 32'(countC), 32'd1);
        checkOutput("c_good_data", 32'(dataC), 32'h2B);

        txLine = 1'b0;
        tick(CPB);
        txLine = 1'b1;
        tick(CPB);
        txLine = 1'b0;
        tick(5);
        checkOutput("c_midframe", 32'(readyC), 32'd0);
        resetC = 1'b1;
        tick(1);
        resetC = 1'b0;
        txLine = 1'b1;
        checkOutput("c_rst_ready", 32'(readyC), 32'd1);
        checkOutput("c_rst_count", 32'(countC), 32'd0);
        tick(40);
        applyStimulus(8'h12, 7, 0, 1'b0, 2, 2'b11, -1, 0);
        checkOutput("c_post_count", 32'(countC), 32'd1);
        checkOutput("c_post_data", 32'(dataC), 32'h12);
        checkOutput("c_post_pulses", 32'(feCnt[2] + peCnt[2] + ovCnt[2]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
